// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy change payout controller with three finite coin tubes
module change_dispenser #(
  parameter int WIDTH    = 8,
  parameter int CW       = 4,
  parameter int TUBE_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_amount,
  output logic             req_ready,
  input  logic             load_valid,
  input  logic [1:0]       load_sel,
  input  logic [CW-1:0]    load_count,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  input  logic             coin_ack,
  output logic             done,
  output logic [WIDTH-1:0] short,
  output logic [CW-1:0]    cnt1,
  output logic [CW-1:0]    cnt5,
  output logic [CW-1:0]    cnt10
);

  typedef enum logic [1:0] {IDLE, SELECT, EJECT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] remaining;
  logic [WIDTH-1:0] denom;
  logic             pick_valid;
  logic [1:0]       pick_sel;
  logic             ack_take;
  logic [CW-1:0]    cnt1_nx, cnt5_nx, cnt10_nx;

  // Sum is formed one bit wider so a restock past capacity saturates instead of wrapping.
  function automatic logic [CW-1:0] tube_next(input logic [CW-1:0] cur, input logic add_en,
                                              input logic [CW-1:0] amt, input logic sub_en);
    logic [CW:0] sum;
    sum = {1'b0, cur} + (add_en ? {1'b0, amt} : '0) - {{CW{1'b0}}, sub_en};
    if (sum > (CW+1)'(TUBE_MAX)) return CW'(TUBE_MAX);
    return sum[CW-1:0];
  endfunction

  assign req_ready  = (state == IDLE);
  assign coin_valid = (state == EJECT);
  assign done       = (state == DONE);
  assign ack_take   = (state == EJECT) && coin_ack;

  always_comb begin
    denom = '0;
    case (coin_sel)
      2'd0:    denom = WIDTH'(1);
      2'd1:    denom = WIDTH'(5);
      2'd2:    denom = WIDTH'(10);
      default: denom = '0;
    endcase
  end

  always_comb begin
    state_nx   = state;
    pick_valid = 1'b0;
    pick_sel   = 2'd0;
    case (state)
      IDLE:   if (req_valid) state_nx = SELECT;
      SELECT: begin
        if (remaining >= WIDTH'(10) && cnt10 != '0) begin
          pick_valid = 1'b1;
          pick_sel   = 2'd2;
        end else if (remaining >= WIDTH'(5) && cnt5 != '0) begin
          pick_valid = 1'b1;
          pick_sel   = 2'd1;
        end else if (remaining >= WIDTH'(1) && cnt1 != '0) begin
          pick_valid = 1'b1;
          pick_sel   = 2'd0;
        end
        state_nx = pick_valid ? EJECT : DONE;
      end
      EJECT:  if (coin_ack) state_nx = SELECT;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cnt1_nx  = tube_next(cnt1,  load_valid && load_sel == 2'd0, load_count, ack_take && coin_sel == 2'd0);
    cnt5_nx  = tube_next(cnt5,  load_valid && load_sel == 2'd1, load_count, ack_take && coin_sel == 2'd1);
    cnt10_nx = tube_next(cnt10, load_valid && load_sel == 2'd2, load_count, ack_take && coin_sel == 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      short     <= '0;
      coin_sel  <= 2'd0;
      cnt1      <= '0;
      cnt5      <= '0;
      cnt10     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid)
        remaining <= req_amount;
      else if (ack_take)
        remaining <= remaining - denom;
      if (pick_valid)
        coin_sel <= pick_sel;
      // short is captured on entry to DONE so it is already valid during the done pulse.
      if (state == SELECT && !pick_valid)
        short <= remaining;
      cnt1  <= cnt1_nx;
      cnt5  <= cnt5_nx;
      cnt10 <= cnt10_nx;
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed scoreboard bench for change_dispenser
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_amount;
  logic       req_ready;
  logic       load_valid;
  logic [1:0] load_sel;
  logic [3:0] load_count;
  logic       coin_valid;
  logic [1:0] coin_sel;
  logic       coin_ack;
  logic       done;
  logic [7:0] short_o;
  logic [3:0] cnt1, cnt5, cnt10;

  int checks = 0;
  int errors = 0;
  int exp_coin[$];
  int exp_short[$];

  change_dispenser dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
    .load_valid(load_valid), .load_sel(load_sel), .load_count(load_count),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .coin_ack(coin_ack),
    .done(done), .short(short_o),
    .cnt1(cnt1), .cnt5(cnt5), .cnt10(cnt10)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic load(input int sel, input int n);
    load_valid = 1'b1;
    load_sel   = sel[1:0];
    load_count = n[3:0];
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic check_counts(input string tag, input int c10, input int c5, input int c1);
    check({tag, "_cnt10"}, 32'(cnt10), c10);
    check({tag, "_cnt5"},  32'(cnt5),  c5);
    check({tag, "_cnt1"},  32'(cnt1),  c1);
  endtask

  // Issues one request, acks coins from the scoreboard, optionally stalls the first coin
  // and optionally restocks the 1-dollar tube on the first ack edge.
  task automatic run_req(input int amount, input int stall, input int ack_load, input int exp_lat);
    int         cyc;
    int         stall_left;
    bit         got_done;
    bit         first_ack;
    int         e;
    logic [1:0] held_sel;
    logic [3:0] s1, s5, s10;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("req_ready_before", 32'(req_ready), 1);
    req_valid  = 1'b1;
    req_amount = amount[7:0];
    @(negedge clk);
    req_valid  = 1'b0;
    req_amount = '0;
    cyc        = 1;
    stall_left = stall;
    got_done   = 1'b0;
    first_ack  = 1'b1;
    while (!got_done && cyc < 200) begin
      coin_ack   = 1'b0;
      load_valid = 1'b0;
      if (coin_valid) begin
        if (stall_left > 0) begin
          held_sel = coin_sel;
          s1 = cnt1; s5 = cnt5; s10 = cnt10;
          for (int k = 0; k < stall_left; k++) begin
            @(negedge clk);
            cyc++;
            check("stall_coin_valid", 32'(coin_valid), 1);
            check("stall_coin_sel", 32'(coin_sel), 32'(held_sel));
            check("stall_cnt1", 32'(cnt1), 32'(s1));
            check("stall_cnt5", 32'(cnt5), 32'(s5));
            check("stall_cnt10", 32'(cnt10), 32'(s10));
          end
          stall_left = 0;
        end
        if (exp_coin.size() == 0) begin
          check("unexpected_coin", 32'(coin_sel), 3);
        end else begin
          e = exp_coin.pop_front();
          check("coin_sel", 32'(coin_sel), e);
        end
        coin_ack = 1'b1;
        if (first_ack && ack_load >= 0) begin
          load_valid = 1'b1;
          load_sel   = 2'd0;
          load_count = ack_load[3:0];
        end
        first_ack = 1'b0;
      end else if (done) begin
        got_done = 1'b1;
        e = (exp_short.size() != 0) ? exp_short.pop_front() : -1;
        check("short", 32'(short_o), e);
        check("latency", cyc, exp_lat);
        check("coins_left", exp_coin.size(), 0);
      end
      if (!got_done) begin
        @(negedge clk);
        cyc++;
      end
    end
    coin_ack   = 1'b0;
    load_valid = 1'b0;
    if (!got_done) check("done_timeout", 0, 1);
    exp_coin.delete();
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_amount = '0;
    load_valid = 1'b0; load_sel = '0; load_count = '0; coin_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_coin_valid", 32'(coin_valid), 0);
    check("rst_coin_sel", 32'(coin_sel), 0);
    check("rst_done", 32'(done), 0);
    check("rst_short", 32'(short_o), 0);
    check_counts("rst", 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);

    load(2, 3); load(1, 2); load(0, 4);
    check_counts("load", 3, 2, 4);

    exp_coin = '{2, 2, 1, 0, 0}; exp_short.push_back(0);
    run_req(27, 0, -1, 12);
    check_counts("full", 1, 1, 2);

    exp_coin = '{2}; exp_short.push_back(0);
    run_req(10, 0, -1, 4);
    check_counts("drain10", 0, 1, 2);

    exp_coin = '{1, 0, 0}; exp_short.push_back(2);
    run_req(9, 0, -1, 8);
    check_counts("short", 0, 0, 0);

    exp_short.push_back(7);
    run_req(7, 0, -1, 2);

    @(negedge clk);
    load(0, 15);
    check("sat_pre_cnt1", 32'(cnt1), 15);
    load(0, 4);
    check("sat_cnt1", 32'(cnt1), 15);

    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    check("idle_ack_coin_valid", 32'(coin_valid), 0);
    check("idle_ack_req_ready", 32'(req_ready), 1);
    check_counts("idle_ack", 0, 0, 15);

    exp_short.push_back(0);
    run_req(0, 0, -1, 2);

    @(negedge clk);
    load(1, 1);
    exp_coin = '{1, 0}; exp_short.push_back(0);
    run_req(6, 5, -1, 11);
    check_counts("stall", 0, 0, 14);

    @(negedge clk);
    load(2, 2);
    req_valid = 1'b1; req_amount = 8'd20;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_coin_valid", 32'(coin_valid), 1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_coin_valid", 32'(coin_valid), 0);
    check("mid_rst_done", 32'(done), 0);
    check_counts("mid_rst", 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", 32'(req_ready), 1);
    check("mid_rst_done_after", 32'(done), 0);

    load(0, 3);
    check("pre_sim_cnt1", 32'(cnt1), 3);
    exp_coin = '{0}; exp_short.push_back(0);
    run_req(1, 0, 2, 4);
    check("sim_load_ack_cnt1", 32'(cnt1), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
